// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//  Shared types and constants for the IF/MEM memory bus arbiter.
//  arb_state_e : bus FSM states (one transaction outstanding at a time)
//  owner_e     : which requester owns the transaction in flight
//  SIZE_WORD   : bus_size code used for every instruction fetch
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

   localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//  Shares one SRAM-like memory port between instruction fetch (IF) and
//  load/store (MEM) of the 5-stage core, raises stall requests for the
//  hazard unit and holds returned read data until the pipeline advances.
//
//  Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   pipe_stall, flush        pipeline advance / exception flush from the core
//   inst_req/addr/rdata      IF side: request, fetch address, held instruction
//   data_req/we/size/addr/
//   data_wdata/rdata         MEM side: access request fields, held load data
//   stallreq_from_if/mem     requester still waiting for its access
//   bus_req/wr/size/addr/
//   bus_wdata                registered SRAM-like request towards the bridge
//   bus_addr_ok/data_ok/
//   bus_rdata                bridge handshake and read data
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter bit DATA_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_stall,
   input  logic              flush,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              stallreq_from_if,
   output logic              stallreq_from_mem,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata
);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              discard_q, discard_d;
   logic              inst_done_q, inst_done_d;
   logic              data_done_q, data_done_d;
   logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_wr_q, bus_wr_d;
   logic [1:0]        bus_size_q, bus_size_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

   logic inst_elig;
   logic data_elig;
   logic grant_data;
   logic complete;

   // A requester that already finished stays ineligible until the pipeline
   // advances, which is what guarantees the other side the next grant.
   assign inst_elig  = inst_req & ~inst_done_q;
   assign data_elig  = data_req & ~data_done_q;
   assign grant_data = data_elig & (DATA_FIRST | ~inst_elig);

   assign stallreq_from_if  = inst_req & ~inst_done_q;
   assign stallreq_from_mem = data_req & ~data_done_q;

   assign inst_rdata = inst_rdata_q;
   assign data_rdata = data_rdata_q;
   assign bus_req    = bus_req_q;
   assign bus_wr     = bus_wr_q;
   assign bus_size   = bus_size_q;
   assign bus_addr   = bus_addr_q;
   assign bus_wdata  = bus_wdata_q;

   // Next-state logic. Done flags are cleared first whenever the pipeline
   // advances or flushes; a completion later in this block sets them again,
   // so a set in the same cycle wins over the clear. A transaction already
   // on the bus cannot be aborted, so flush only marks it for discard.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      discard_d    = discard_q;
      inst_done_d  = inst_done_q & pipe_stall & ~flush;
      data_done_d  = data_done_q & pipe_stall & ~flush;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      bus_req_d    = bus_req_q;
      bus_wr_d     = bus_wr_q;
      bus_size_d   = bus_size_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      complete     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            discard_d = 1'b0;
            if (!flush && (inst_elig || data_elig)) begin
               state_d   = ST_ADDR;
               bus_req_d = 1'b1;
               if (grant_data) begin
                  owner_d     = OWN_DATA;
                  bus_wr_d    = data_we;
                  bus_size_d  = data_size;
                  bus_addr_d  = data_addr;
                  bus_wdata_d = data_wdata;
               end else begin
                  owner_d     = OWN_INST;
                  bus_wr_d    = 1'b0;
                  bus_size_d  = SIZE_WORD;
                  bus_addr_d  = inst_addr;
                  bus_wdata_d = '0;
               end
            end
         end
         ST_ADDR: begin
            if (flush) discard_d = 1'b1;
            if (bus_addr_ok) begin
               bus_req_d = 1'b0;
               if (bus_data_ok) complete = 1'b1;
               else             state_d  = ST_DATA;
            end
         end
         ST_DATA: begin
            if (flush) discard_d = 1'b1;
            if (bus_data_ok) complete = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // A flush arriving in the completing cycle also discards the result.
      if (complete) begin
         state_d   = ST_IDLE;
         discard_d = 1'b0;
         if (!discard_q && !flush) begin
            if (owner_q == OWN_INST) begin
               inst_done_d = 1'b1;
               if (!bus_wr_q) inst_rdata_d = bus_rdata;
            end else begin
               data_done_d = 1'b1;
               if (!bus_wr_q) data_rdata_d = bus_rdata;
            end
         end
      end
   end

   // State and output registers; reset drops bus_req immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_INST;
         discard_q    <= 1'b0;
         inst_done_q  <= 1'b0;
         data_done_q  <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
         bus_req_q    <= 1'b0;
         bus_wr_q     <= 1'b0;
         bus_size_q   <= 2'd0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         discard_q    <= discard_d;
         inst_done_q  <= inst_done_d;
         data_done_q  <= data_done_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         bus_req_q    <= bus_req_d;
         bus_wr_q     <= bus_wr_d;
         bus_size_q   <= bus_size_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//  Directed bench for mem_bus_arbiter. A bridge model answers bus requests
//  with configurable latencies and a queue of read data; bus requests
//  expected by each scenario are queued and a monitor compares them as the
//  DUT's requests are accepted.
module tb_mem_bus_arbiter;

   logic        clk;
   logic        rst;
   logic        pipe_stall;
   logic        flush;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_we;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        stallreq_from_if;
   logic        stallreq_from_mem;
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] wdata;
   } bus_exp_t;

   bus_exp_t    exp_q[$];
   logic [31:0] rdata_q[$];
   int          total;
   int          bad;
   int          slv_addr_lat;
   int          slv_data_lat;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1'b1)) dut (
      .clk               (clk),
      .rst               (rst),
      .pipe_stall        (pipe_stall),
      .flush             (flush),
      .inst_req          (inst_req),
      .inst_addr         (inst_addr),
      .inst_rdata        (inst_rdata),
      .data_req          (data_req),
      .data_we           (data_we),
      .data_size         (data_size),
      .data_addr         (data_addr),
      .data_wdata        (data_wdata),
      .data_rdata        (data_rdata),
      .stallreq_from_if  (stallreq_from_if),
      .stallreq_from_mem (stallreq_from_mem),
      .bus_req           (bus_req),
      .bus_wr            (bus_wr),
      .bus_size          (bus_size),
      .bus_addr          (bus_addr),
      .bus_wdata         (bus_wdata),
      .bus_addr_ok       (bus_addr_ok),
      .bus_data_ok       (bus_data_ok),
      .bus_rdata         (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic dwe,
                                input logic [1:0] dsize, input logic [31:0] daddr,
                                input logic [31:0] dwdata);
      inst_req   = ireq;
      inst_addr  = iaddr;
      data_req   = dreq;
      data_we    = dwe;
      data_size  = dsize;
      data_addr  = daddr;
      data_wdata = dwdata;
   endtask

   task automatic expectBus(input logic [31:0] addr, input logic wr,
                            input logic [1:0] size, input logic [31:0] wdata);
      bus_exp_t e;
      e.addr  = addr;
      e.wr    = wr;
      e.size  = size;
      e.wdata = wdata;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the caller at the negedge of the cycle in which data_ok is high.
   task automatic waitDataOk(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus_data_ok && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!bus_data_ok) begin
         total++;
         bad++;
         $display("[TB] FAIL %s: data_ok never seen, got 0, wanted 1", name);
      end
   endtask

   task automatic waitAccept(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!(bus_req && bus_addr_ok) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!(bus_req && bus_addr_ok)) begin
         total++;
         bad++;
         $display("[TB] FAIL %s: request never accepted, got 0, wanted 1", name);
      end
   endtask

   // Bridge model: accepts a request after slv_addr_lat cycles, returns
   // data_ok slv_data_lat cycles later (0 = same cycle as addr_ok), and
   // abandons a request that disappears before acceptance (reset).
   initial begin
      int   n;
      logic live;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = '0;
      forever begin
         @(posedge clk);
         #1;
         bus_addr_ok = 1'b0;
         bus_data_ok = 1'b0;
         if (bus_req) begin
            n    = 0;
            live = 1'b1;
            while (live && n < slv_addr_lat) begin
               @(posedge clk);
               #1;
               n++;
               live = bus_req;
            end
            if (live) begin
               bus_addr_ok = 1'b1;
               if (slv_data_lat == 0) begin
                  bus_data_ok = 1'b1;
                  bus_rdata   = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
               end
               @(posedge clk);
               #1;
               bus_addr_ok = 1'b0;
               bus_data_ok = 1'b0;
               if (slv_data_lat > 0) begin
                  repeat (slv_data_lat - 1) begin
                     @(posedge clk);
                     #1;
                  end
                  bus_data_ok = 1'b1;
                  bus_rdata   = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
                  @(posedge clk);
                  #1;
                  bus_data_ok = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: every accepted bus request must match the next expected one.
   initial begin
      bus_exp_t e;
      forever begin
         @(negedge clk);
         if (rst && bus_req && bus_addr_ok) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_req: got addr 0x%08h, wanted no request", bus_addr);
            end else begin
               e = exp_q.pop_front();
               checkOutput("bus_addr",  bus_addr,          e.addr);
               checkOutput("bus_wr",    {31'd0, bus_wr},   {31'd0, e.wr});
               checkOutput("bus_size",  {30'd0, bus_size}, {30'd0, e.size});
               checkOutput("bus_wdata", bus_wdata,         e.wdata);
            end
         end
      end
   end

   // Let the pipeline advance once with no requests so both done flags clear.
   task automatic advance();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      pipe_stall = 1'b0;
      tick();
      pipe_stall = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time exhausted, got timeout, wanted finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      total        = 0;
      bad          = 0;
      slv_addr_lat = 1;
      slv_data_lat = 2;
      rst          = 1'b0;
      pipe_stall   = 1'b1;
      flush        = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_bus_req",    {31'd0, bus_req}, 32'd0);
      checkOutput("rst_bus_addr",   bus_addr,         32'd0);
      checkOutput("rst_inst_rdata", inst_rdata,       32'd0);
      checkOutput("rst_data_rdata", data_rdata,       32'd0);
      tick();
      rst = 1'b1;
      tick();

      // Fetch only
      expectBus(32'hBFC00000, 1'b0, 2'd2, 32'h0);
      rdata_q.push_back(32'h3C1D8000);
      applyStimulus(1'b1, 32'hBFC00000, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("fetch_stall_before", {31'd0, stallreq_from_if}, 32'd1);
      waitDataOk("fetch_data_ok");
      @(negedge clk);
      checkOutput("fetch_stall_after", {31'd0, stallreq_from_if}, 32'd0);
      checkOutput("fetch_rdata",       inst_rdata,                32'h3C1D8000);
      tick();
      advance();

      // Simultaneous requests, load wins, fetch re-arbitrated after
      slv_addr_lat = 0;
      slv_data_lat = 1;
      expectBus(32'h80001000, 1'b0, 2'd2, 32'h0);
      expectBus(32'hBFC00004, 1'b0, 2'd2, 32'h0);
      rdata_q.push_back(32'h11223344);
      rdata_q.push_back(32'h55667788);
      applyStimulus(1'b1, 32'hBFC00004, 1'b1, 1'b0, 2'd2, 32'h80001000, 32'h0);
      waitDataOk("load_data_ok");
      @(negedge clk);
      checkOutput("sim_gap_bus_req", {31'd0, bus_req},           32'd0);
      checkOutput("sim_load_rdata",  data_rdata,                 32'h11223344);
      checkOutput("sim_mem_stall",   {31'd0, stallreq_from_mem}, 32'd0);
      checkOutput("sim_if_stall",    {31'd0, stallreq_from_if},  32'd1);
      @(negedge clk);
      checkOutput("sim_fetch_issue", {31'd0, bus_req}, 32'd1);
      checkOutput("sim_fetch_addr",  bus_addr,         32'hBFC00004);
      waitDataOk("sim_fetch_data_ok");
      @(negedge clk);
      checkOutput("sim_fetch_rdata", inst_rdata, 32'h55667788);
      tick();
      advance();

      // Store byte: data passes through untouched, load data unchanged
      expectBus(32'h80000003, 1'b1, 2'd0, 32'hAB000000);
      rdata_q.push_back(32'hDEADBEEF);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'd0, 32'h80000003, 32'hAB000000);
      @(negedge clk);
      checkOutput("store_stall_before", {31'd0, stallreq_from_mem}, 32'd1);
      waitDataOk("store_data_ok");
      @(negedge clk);
      checkOutput("store_stall_after", {31'd0, stallreq_from_mem}, 32'd0);
      checkOutput("store_rdata_kept",  data_rdata,                 32'h11223344);
      tick();
      advance();

      // Flush while the fetch sits in DATA
      slv_addr_lat = 0;
      slv_data_lat = 3;
      expectBus(32'h00000100, 1'b0, 2'd2, 32'h0);
      expectBus(32'hBFC00380, 1'b0, 2'd2, 32'h0);
      rdata_q.push_back(32'hCAFEF00D);
      rdata_q.push_back(32'h24080001);
      applyStimulus(1'b1, 32'h00000100, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      waitAccept("flush_accept");
      tick();
      flush     = 1'b1;
      inst_addr = 32'hBFC00380;
      tick();
      flush = 1'b0;
      waitDataOk("flush_late_data_ok");
      @(negedge clk);
      checkOutput("flush_rdata_kept", inst_rdata,               32'h55667788);
      checkOutput("flush_still_stall", {31'd0, stallreq_from_if}, 32'd1);
      @(negedge clk);
      checkOutput("flush_reissue",      {31'd0, bus_req}, 32'd1);
      checkOutput("flush_reissue_addr", bus_addr,         32'hBFC00380);
      waitDataOk("flush_new_data_ok");
      @(negedge clk);
      checkOutput("flush_new_rdata", inst_rdata, 32'h24080001);
      tick();
      advance();

      // Hold under stall: both complete, no reissue while stalled
      slv_addr_lat = 0;
      slv_data_lat = 1;
      expectBus(32'h80002000, 1'b0, 2'd2, 32'h0);
      expectBus(32'hBFC00008, 1'b0, 2'd2, 32'h0);
      rdata_q.push_back(32'h000000A1);
      rdata_q.push_back(32'h000000B2);
      applyStimulus(1'b1, 32'hBFC00008, 1'b1, 1'b0, 2'd2, 32'h80002000, 32'h0);
      waitDataOk("hold_load_data_ok");
      waitDataOk("hold_fetch_data_ok");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold_no_reissue", {31'd0, bus_req}, 32'd0);
         checkOutput("hold_inst_rdata", inst_rdata,       32'h000000B2);
         checkOutput("hold_data_rdata", data_rdata,       32'h000000A1);
      end
      checkOutput("hold_if_quiet",  {31'd0, stallreq_from_if},  32'd0);
      checkOutput("hold_mem_quiet", {31'd0, stallreq_from_mem}, 32'd0);
      pipe_stall = 1'b0;
      @(negedge clk);
      checkOutput("hold_if_done_clr",  {31'd0, stallreq_from_if},  32'd1);
      checkOutput("hold_mem_done_clr", {31'd0, stallreq_from_mem}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      pipe_stall = 1'b1;
      @(negedge clk);
      checkOutput("hold_after_bus_req", {31'd0, bus_req}, 32'd0);
      tick();

      // Reset while the request waits for addr_ok
      slv_addr_lat = 5;
      applyStimulus(1'b1, 32'h00000200, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_mid_req_up", {31'd0, bus_req}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("rst_async_drop", {31'd0, bus_req}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      repeat (8) tick();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_mid_bus_req",    {31'd0, bus_req}, 32'd0);
      checkOutput("rst_mid_inst_rdata", inst_rdata,       32'd0);
      checkOutput("rst_mid_data_rdata", data_rdata,       32'd0);
      checkOutput("rst_mid_bus_addr",   bus_addr,         32'd0);

      checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
